// File: rtl/bit_permute_pkg.sv
// rtl/bit_permute_pkg.sv - mode constants and FSM state encoding for the bit permute unit
package bit_permute_pkg;

  localparam logic [2:0] MODE_PASS    = 3'd0;
  localparam logic [2:0] MODE_BREV    = 3'd1;
  localparam logic [2:0] MODE_BYTEREV = 3'd2;
  localparam logic [2:0] MODE_BREV8   = 3'd3;
  localparam logic [2:0] MODE_ROTL    = 3'd4;
  localparam logic [2:0] MODE_ROTR    = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ROT  = 1'b1
  } state_t;

endpackage

// File: rtl/bit_permute_net.sv
// rtl/bit_permute_net.sv - combinational pass / bit-reverse / byte-reverse / bit-reverse-in-byte network
module bit_permute_net
  import bit_permute_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] result
);

  localparam int NB = WIDTH / 8;

  always_comb begin
    result = data;
    case (sel)
      MODE_BREV[1:0]: begin
        for (int i = 0; i < WIDTH; i++) result[i] = data[WIDTH-1-i];
      end
      MODE_BYTEREV[1:0]: begin
        for (int k = 0; k < NB; k++) result[8*k +: 8] = data[8*(NB-1-k) +: 8];
      end
      MODE_BREV8[1:0]: begin
        for (int k = 0; k < NB; k++) begin
          for (int j = 0; j < 8; j++) result[8*k+j] = data[8*k+7-j];
        end
      end
      default: result = data;
    endcase
  end

endmodule

// File: rtl/bit_permute_unit.sv
// rtl/bit_permute_unit.sv - handshaked permute unit with iterative one-bit-per-clock rotate
module bit_permute_unit
  import bit_permute_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    rot_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_next;
  logic [AW-1:0]    cnt_q;
  logic             dir_q;
  logic [1:0]       net_sel;
  logic [WIDTH-1:0] net_result;
  logic             is_rot;
  logic             accept;
  logic             rot_start;
  logic             rot_done;

  // Modes 4..7 all reach the network as pass; rotates with zero distance complete immediately.
  assign net_sel = mode[2] ? MODE_PASS[1:0] : mode[1:0];

  bit_permute_net #(.WIDTH(WIDTH)) u_net (
    .data   (in_data),
    .sel    (net_sel),
    .result (net_result)
  );

  assign is_rot    = (mode == MODE_ROTL) || (mode == MODE_ROTR);
  assign accept    = in_valid && in_ready;
  assign rot_start = accept && is_rot && (rot_amt != '0);
  assign rot_done  = (state_q == ST_ROT) && (cnt_q == AW'(1));
  assign work_next = dir_q ? {work_q[0], work_q[WIDTH-1:1]}
                           : {work_q[WIDTH-2:0], work_q[WIDTH-1]};

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == ST_IDLE) && (!out_valid || out_ready) && !rst;
    busy     = (state_q == ST_ROT);
    case (state_q)
      ST_IDLE: if (rot_start) state_d = ST_ROT;
      ST_ROT:  if (rot_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q <= state_d;
      if (rot_start) begin
        work_q <= in_data;
        cnt_q  <= rot_amt;
        dir_q  <= mode[0];
      end else if (state_q == ST_ROT) begin
        work_q <= work_next;
        cnt_q  <= cnt_q - AW'(1);
      end
      // A new result takes priority over the consume so that reload keeps out_valid high.
      if (accept && !rot_start) begin
        out_data  <= net_result;
        out_valid <= 1'b1;
      end else if (rot_done) begin
        out_data  <= work_next;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_permute_unit.sv
// tb/tb_bit_permute_unit.sv - directed table-driven bench for bit_permute_unit at WIDTH 32 and 64
module tb_bit_permute_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  mode = 3'd0;
  logic [5:0]  amt = 6'd0;
  logic [63:0] din = 64'd0;
  logic        out_ready = 1'b1;
  logic        iv32 = 1'b0, iv64 = 1'b0;
  logic        ir32, ov32, bz32, ir64, ov64, bz64;
  logic [31:0] od32;
  logic [63:0] od64;
  logic        sel_wide = 1'b0;
  logic        ir, ov, bz;
  logic [63:0] od;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  assign ir = sel_wide ? ir64 : ir32;
  assign ov = sel_wide ? ov64 : ov32;
  assign bz = sel_wide ? bz64 : bz32;
  assign od = sel_wide ? od64 : {32'd0, od32};

  bit_permute_unit #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_data(din[31:0]),
    .mode(mode), .rot_amt(amt[4:0]), .out_valid(ov32), .out_ready(out_ready),
    .out_data(od32), .busy(bz32)
  );

  bit_permute_unit #(.WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .in_data(din),
    .mode(mode), .rot_amt(amt), .out_valid(ov64), .out_ready(out_ready),
    .out_data(od64), .busy(bz64)
  );

  typedef struct {
    bit          wide;
    logic [2:0]  mode;
    logic [5:0]  amt;
    logic [63:0] data;
    logic [63:0] exp;
    int          lat;
    int          nbusy;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] sw[8];
  logic [31:0] se[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int w, lat, nb, nir;
    tick();
    sel_wide = v.wide;
    mode = v.mode;
    amt  = v.amt;
    din  = v.data;
    if (v.wide) iv64 = 1'b1; else iv32 = 1'b1;
    w = 0;
    while (!ir && w < 100) begin
      tick();
      w++;
    end
    chk($sformatf("v%0d in_ready", idx), {63'd0, ir}, 64'd1);
    tick();
    iv32 = 1'b0;
    iv64 = 1'b0;
    lat = 1; nb = 0; nir = 0;
    while (!ov && lat < 200) begin
      if (bz) nb++;
      if (!ir) nir++;
      tick();
      lat++;
    end
    chk($sformatf("v%0d out_data", idx), od, v.exp);
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d busy cycles", idx), 64'(nb), 64'(v.nbusy));
    chk($sformatf("v%0d in_ready low cycles", idx), 64'(nir), 64'(v.nbusy));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nov;
    vecs[0]  = '{1'b0, 3'd1, 6'd0,  64'h1,                  64'h80000000,           1,  0};
    vecs[1]  = '{1'b0, 3'd1, 6'd0,  64'hF0000000,           64'h0000000F,           1,  0};
    vecs[2]  = '{1'b0, 3'd2, 6'd5,  64'h12345678,           64'h78563412,           1,  0};
    vecs[3]  = '{1'b0, 3'd3, 6'd0,  64'h01020380,           64'h8040C001,           1,  0};
    vecs[4]  = '{1'b0, 3'd6, 6'd0,  64'hDEADBEEF,           64'hDEADBEEF,           1,  0};
    vecs[5]  = '{1'b0, 3'd7, 6'd3,  64'h0000A5A5,           64'h0000A5A5,           1,  0};
    vecs[6]  = '{1'b0, 3'd4, 6'd4,  64'h80000001,           64'h00000018,           5,  4};
    vecs[7]  = '{1'b0, 3'd5, 6'd1,  64'h00000001,           64'h80000000,           2,  1};
    vecs[8]  = '{1'b0, 3'd4, 6'd0,  64'h12345678,           64'h12345678,           1,  0};
    vecs[9]  = '{1'b0, 3'd5, 6'd31, 64'h80000001,           64'h00000003,           32, 31};
    vecs[10] = '{1'b0, 3'd0, 6'd0,  64'hCAFEF00D,           64'hCAFEF00D,           1,  0};
    vecs[11] = '{1'b1, 3'd2, 6'd0,  64'h0123456789ABCDEF,   64'hEFCDAB8967452301,   1,  0};
    vecs[12] = '{1'b1, 3'd4, 6'd63, 64'h0123456789ABCDEF,   64'h8091A2B3C4D5E6F7,   64, 63};
    vecs[13] = '{1'b1, 3'd3, 6'd0,  64'h0000000000000001,   64'h0000000000000080,   1,  0};

    sw[0] = 32'h00000001; se[0] = 32'h80000000;
    sw[1] = 32'h00000002; se[1] = 32'h40000000;
    sw[2] = 32'h00000004; se[2] = 32'h20000000;
    sw[3] = 32'h00000008; se[3] = 32'h10000000;
    sw[4] = 32'h00000010; se[4] = 32'h08000000;
    sw[5] = 32'h00000003; se[5] = 32'hC0000000;
    sw[6] = 32'h0000000F; se[6] = 32'hF0000000;
    sw[7] = 32'hFFFF0000; se[7] = 32'h0000FFFF;

    // reset state
    tick();
    tick();
    chk("rst out_valid32", {63'd0, ov32}, 64'd0);
    chk("rst out_data32", {32'd0, od32}, 64'd0);
    chk("rst busy32", {63'd0, bz32}, 64'd0);
    chk("rst in_ready32 held", {63'd0, ir32}, 64'd0);
    chk("rst out_valid64", {63'd0, ov64}, 64'd0);
    chk("rst out_data64", od64, 64'd0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready32", {63'd0, ir32}, 64'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);
    sel_wide = 1'b0;

    // backpressure: hold result while out_ready low, accept next on release
    tick();
    out_ready = 1'b0;
    mode = 3'd1; amt = 6'd0; din = 64'h1; iv32 = 1'b1;
    chk("bp first ready", {63'd0, ir32}, 64'd1);
    tick();
    mode = 3'd2; din = 64'h12345678;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp hold data %0d", i), {32'd0, od32}, 64'h80000000);
      chk($sformatf("bp hold valid %0d", i), {63'd0, ov32}, 64'd1);
      chk($sformatf("bp in_ready low %0d", i), {63'd0, ir32}, 64'd0);
      tick();
    end
    chk("bp stall data", {32'd0, od32}, 64'h80000000);
    out_ready = 1'b1;
    #1;
    chk("bp in_ready on release", {63'd0, ir32}, 64'd1);
    tick();
    iv32 = 1'b0;
    chk("bp reload valid", {63'd0, ov32}, 64'd1);
    chk("bp reload data", {32'd0, od32}, 64'h78563412);

    // back-to-back stream of bit-reversed words
    tick();
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        chk($sformatf("stream valid %0d", k - 1), {63'd0, ov32}, 64'd1);
        chk($sformatf("stream data %0d", k - 1), {32'd0, od32}, {32'd0, se[k-1]});
      end
      if (k < 8) begin
        mode = 3'd1; din = {32'd0, sw[k]}; iv32 = 1'b1;
        chk($sformatf("stream ready %0d", k), {63'd0, ir32}, 64'd1);
      end else begin
        iv32 = 1'b0;
      end
      tick();
    end

    // reset during the second cycle of a 10-step rotate
    mode = 3'd4; amt = 6'd10; din = 64'h1; iv32 = 1'b1;
    tick();
    iv32 = 1'b0;
    chk("rr busy after accept", {63'd0, bz32}, 64'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("rr busy cleared", {63'd0, bz32}, 64'd0);
    chk("rr out_valid cleared", {63'd0, ov32}, 64'd0);
    chk("rr out_data cleared", {32'd0, od32}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rr in_ready after rst", {63'd0, ir32}, 64'd1);
    nov = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ov32) nov++;
    end
    chk("rr no orphan result", 64'(nov), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
